xg_scoreboard: RTL and testbench
================================

XG_SCOREBOARD -- requirements
Module: xg_scoreboard

Interface
REQ-001 Parameter XLEN, default 32: operand and result width.
REQ-002 Parameter RFIDX_WIDTH, default 5: register index width; x0 is hard-wired zero.
REQ-003 Parameter DEPTH, default 3: number of tracked post-decode stages (0 = EX, DEPTH-1 = WB); legal range 2..6.
REQ-004 Parameter LOAD_LAT, default 2: first stage index where load data is valid; ALU results are valid from stage 1. Legal range 1..DEPTH-1.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Ports issue_valid (input, 1), issue_regwrite (input, 1), issue_load (input, 1) and issue_rd (input, RFIDX_WIDTH): describe the instruction currently in decode.
REQ-008 Ports rs1 and rs2 (inputs, RFIDX_WIDTH each) and use1 and use2 (inputs, 1 each): decode source indices and their use flags.
REQ-009 Ports rf1 and rf2 (inputs, XLEN each): register-file read data for rs1 and rs2.
REQ-010 Port stage_data (input, DEPTH*XLEN): result bus of each tracked stage; stage k occupies bits [k*XLEN +: XLEN].
REQ-011 Port flush (input, 1): a taken branch or jump resolved in EX.
REQ-012 Ports opa and opb (outputs, XLEN each): forwarded operands.
REQ-013 Ports sel1 and sel2 (outputs, 3 each): 0 = register file, k+1 = stage k.
REQ-014 Port stall (output, 1): hold IF/ID and inject a bubble into EX.
REQ-015 Port stall_cnt (output, 32): saturating count of stall cycles.

Function
REQ-016 The block SHALL keep a shift register of DEPTH entries, each holding {valid, regwrite, load, rd}.
REQ-017 Each cycle the register SHALL shift one position: stage k moves to k+1, and stage DEPTH-1 retires.
REQ-018 Stage 0 SHALL load the decode instruction when issue_valid & !stall & !flush; otherwise stage 0 SHALL load a bubble (valid=0).
REQ-019 When flush=1, the entry leaving stage 0 SHALL be kept, because the branch itself proceeds; only the decode instruction is squashed.
REQ-020 A stage k is a producer for source s when: valid=1, regwrite=1, rd==s, and s!=0.
REQ-021 For each used source, the block SHALL select the lowest-index (youngest) producer stage k, setting sel=k+1 and op=stage_data[k].
REQ-022 If a source has no producer, the block SHALL set sel=0 and op=rf.
REQ-023 The youngest producer is not ready when (load=1 and k<LOAD_LAT) or k<1.
REQ-024 stall SHALL be 1 when use=1 and the youngest producer for that source is not ready; older ready producers SHALL NOT mask this.
REQ-025 stall SHALL be forced to 0 whenever flush=1 or issue_valid=0.
REQ-026 opa, opb, sel and stall SHALL be combinational from the current inputs and state, with zero-cycle latency.
REQ-027 When a source is x0, sel SHALL be 0 and op SHALL be zero, regardless of rf.
REQ-028 stall_cnt SHALL increment on every cycle where stall=1 and SHALL saturate at 0xFFFFFFFF.
REQ-029 When a result is in WB (stage DEPTH-1) and is written to the register file in the same cycle, forwarding SHALL still take priority, so no read-during-write hazard exists.

Reset
REQ-030 When reset=1 at a clock edge, all entries SHALL clear to valid=0 and stall_cnt SHALL clear to 0.
REQ-031 While reset=1, stall SHALL be 0 and sel1 and sel2 SHALL be 0.
REQ-032 A reset asserted mid-stall SHALL abort the stall on the next edge.
REQ-033 Reset SHALL take priority over flush and issue.

Structure
REQ-034 The constants SEL_RF=0 and the ALU-ready stage index (1) SHALL live in the shared defines file alongside XLEN and RFIDX_WIDTH.
REQ-035 The block SHALL use one sub-module, xg_fwd_pick, instantiated twice (once per source), which performs a priority search over the DEPTH entries and returns {sel, ready}.
REQ-036 The stage register and stall_cnt SHALL live in the top module.

Verification (DEPTH=3, LOAD_LAT=2)
REQ-037 ALU back-to-back: add x5 issued, then next cycle rs1=5 with stage_data[0]=0x11 -> sel1=1, opa=0x11, stall=0.
REQ-038 Load-use: lw x6 issued, next cycle rs2=6 -> stall=1 for exactly one cycle; on the following cycle sel2=2, opb=stage_data[1], and stall_cnt=1.
REQ-039 Youngest wins: x7 written by the instructions in stage 2 (0xAA) and stage 0 (0xBB) -> opa=0xBB, sel1=1.
REQ-040 x0 source: rs1=0 while stage 0 writes rd=0 -> sel1=0, opa=0, stall=0.
REQ-041 Flush during load-use: flush=1 in the stall cycle -> stall=0 and stage 0 becomes a bubble; with rf1=0x5 the next-cycle opa=0x5 and sel1=0.
REQ-042 Reset mid-stall: reset=1 while stall=1 -> the next cycle has all entries invalid, stall=0 and stall_cnt=0.

Source files
------------

// File: rtl/xg_scoreboard_pkg.sv
// Shared constants and types for the xg scoreboard / forwarding block.
// Holds the default widths, the forwarding-select encoding and the ALU-ready stage.
package xg_scoreboard_pkg;

    localparam int XG_XLEN         = 32;
    localparam int XG_RFIDX_WIDTH  = 5;
    localparam int SEL_WIDTH       = 3;
    localparam int ALU_READY_STAGE = 1;

    typedef logic [SEL_WIDTH-1:0] sel_t;

    localparam sel_t SEL_RF = '0;

    // Select code for tracked stage k (stage k is reported as k+1, 0 means register file).
    function automatic sel_t stage_sel(input int k);
        return sel_t'(k + 1);
    endfunction

endpackage

// File: rtl/xg_fwd_pick.sv
// Priority search over the tracked stages for one source register.
// Returns the select code of the youngest producer and whether its result is usable yet.
module xg_fwd_pick
    import xg_scoreboard_pkg::*;
#(
    parameter int DEPTH       = 3,
    parameter int RFIDX_WIDTH = XG_RFIDX_WIDTH,
    parameter int LOAD_LAT    = 2
) (
    input  logic [RFIDX_WIDTH-1:0]       src,
    input  logic                         used,
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0]             regwrite,
    input  logic [DEPTH-1:0]             load,
    input  logic [DEPTH*RFIDX_WIDTH-1:0] rd,
    output sel_t                         sel,
    output logic                         ready
);

    // Readiness is judged on the select position (k+1): an ALU result at stage 0 can be
    // forwarded to decode, a load result only once it has reached position LOAD_LAT.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        sel   = SEL_RF;
        ready = 1'b1;
        if (used && (src != '0)) begin
            // Scan oldest to youngest so the youngest matching stage is the last one written.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (valid[k] && regwrite[k] && (rd[k*RFIDX_WIDTH +: RFIDX_WIDTH] == src)) begin
                    sel   = stage_sel(k);
                    ready = ((k + 1) >= ALU_READY_STAGE) && !(load[k] && ((k + 1) < LOAD_LAT));
                end
            end
        end
    end

endmodule

// File: rtl/xg_scoreboard.sv
// Pipeline scoreboard: tracks in-flight writers, forwards operands and raises load-use stalls.
// Forwarding and stall are purely combinational; only the stage register and stall counter are state.
module xg_scoreboard
    import xg_scoreboard_pkg::*;
#(
    parameter int XLEN        = XG_XLEN,
    parameter int RFIDX_WIDTH = XG_RFIDX_WIDTH,
    parameter int DEPTH       = 3,
    parameter int LOAD_LAT    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic                   issue_regwrite,
    input  logic                   issue_load,
    input  logic [RFIDX_WIDTH-1:0] issue_rd,
    input  logic [RFIDX_WIDTH-1:0] rs1,
    input  logic [RFIDX_WIDTH-1:0] rs2,
    input  logic                   use1,
    input  logic                   use2,
    input  logic [XLEN-1:0]        rf1,
    input  logic [XLEN-1:0]        rf2,
    input  logic [DEPTH*XLEN-1:0]  stage_data,
    input  logic                   flush,
    output logic [XLEN-1:0]        opa,
    output logic [XLEN-1:0]        opb,
    output logic [2:0]             sel1,
    output logic [2:0]             sel2,
    output logic                   stall,
    output logic [31:0]            stall_cnt
);

    logic [DEPTH-1:0]             st_valid;
    logic [DEPTH-1:0]             st_regwrite;
    logic [DEPTH-1:0]             st_load;
    logic [DEPTH*RFIDX_WIDTH-1:0] st_rd;

    sel_t pick_sel1, pick_sel2;
    logic ready1, ready2;

    xg_fwd_pick #(
        .DEPTH       (DEPTH),
        .RFIDX_WIDTH (RFIDX_WIDTH),
        .LOAD_LAT    (LOAD_LAT)
    ) u_pick1 (
        .src      (rs1),
        .used     (use1),
        .valid    (st_valid),
        .regwrite (st_regwrite),
        .load     (st_load),
        .rd       (st_rd),
        .sel      (pick_sel1),
        .ready    (ready1)
    );

    xg_fwd_pick #(
        .DEPTH       (DEPTH),
        .RFIDX_WIDTH (RFIDX_WIDTH),
        .LOAD_LAT    (LOAD_LAT)
    ) u_pick2 (
        .src      (rs2),
        .used     (use2),
        .valid    (st_valid),
        .regwrite (st_regwrite),
        .load     (st_load),
        .rd       (st_rd),
        .sel      (pick_sel2),
        .ready    (ready2)
    );

    // Forwarded stage data wins over the register file, which also covers a WB-stage write.
    function automatic logic [XLEN-1:0] fwd_mux(input sel_t sel, input logic [RFIDX_WIDTH-1:0] src,
                                                input logic [XLEN-1:0] rf,
                                                input logic [DEPTH*XLEN-1:0] data);
        logic [XLEN-1:0] op;
        op = rf;
        for (int k = 0; k < DEPTH; k++) begin
            if (sel == stage_sel(k)) op = data[k*XLEN +: XLEN];
        end
        if (src == '0) op = '0;
        return op;
    endfunction

    always_comb begin
        sel1  = reset ? SEL_RF : pick_sel1;
        sel2  = reset ? SEL_RF : pick_sel2;
        opa   = fwd_mux(sel1, rs1, rf1, stage_data);
        opb   = fwd_mux(sel2, rs2, rf2, stage_data);
        stall = !reset && issue_valid && !flush && (!ready1 || !ready2);
    end

    // A flush squashes only the decode slot; the entry leaving stage 0 is the branch and moves on.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_valid  <= '0;
            stall_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all stages shift from pre-edge values.
            st_valid <= {st_valid[DEPTH-2:0], issue_valid && !stall && !flush};
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    // NOTE: payload fields are not reset; they are only ever observed through their valid bit.
    always_ff @(posedge clk) begin
        st_regwrite <= {st_regwrite[DEPTH-2:0], issue_regwrite};
        st_load     <= {st_load[DEPTH-2:0], issue_load};
        st_rd       <= {st_rd[(DEPTH-1)*RFIDX_WIDTH-1:0], issue_rd};
    end

endmodule

// File: tb/tb_xg_scoreboard.sv
// Directed self-checking bench for xg_scoreboard (DEPTH=3, LOAD_LAT=2, XLEN=32).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_xg_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_regwrite, issue_load;
    logic [4:0]  issue_rd, rs1, rs2;
    logic        use1, use2;
    logic [31:0] rf1, rf2;
    logic [95:0] stage_data;
    logic        flush;
    logic [31:0] opa, opb;
    logic [2:0]  sel1, sel2;
    logic        stall;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    xg_scoreboard #(
        .XLEN        (32),
        .RFIDX_WIDTH (5),
        .DEPTH       (3),
        .LOAD_LAT    (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_regwrite (issue_regwrite),
        .issue_load     (issue_load),
        .issue_rd       (issue_rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .use1           (use1),
        .use2           (use2),
        .rf1            (rf1),
        .rf2            (rf2),
        .stage_data     (stage_data),
        .flush          (flush),
        .opa            (opa),
        .opb            (opb),
        .sel1           (sel1),
        .sel2           (sel2),
        .stall          (stall),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic wr, input logic ld, input logic [4:0] rd);
        issue_valid    = 1'b1;
        issue_regwrite = wr;
        issue_load     = ld;
        issue_rd       = rd;
        use1           = 1'b0;
        use2           = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic consumer(input logic u1, input logic [4:0] s1, input logic u2, input logic [4:0] s2);
        issue_valid    = 1'b1;
        issue_regwrite = 1'b0;
        issue_load     = 1'b0;
        issue_rd       = 5'd0;
        use1           = u1;
        rs1            = s1;
        use2           = u2;
        rs2            = s2;
        flush          = 1'b0;
    endtask

    task automatic idle(input int n);
        issue_valid = 1'b0;
        use1        = 1'b0;
        use2        = 1'b0;
        flush       = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1;
        issue_valid = 1'b0; issue_regwrite = 1'b0; issue_load = 1'b0; issue_rd = '0;
        rs1 = '0; rs2 = '0; use1 = 1'b0; use2 = 1'b0;
        rf1 = 32'h99; rf2 = 32'h77; flush = 1'b0;
        stage_data = {32'h33, 32'h22, 32'h11};

        // Reset state, with a consumer in decode
        tick(); tick();
        consumer(1'b1, 5'd5, 1'b1, 5'd6);
        settle();
        check("rst_stall", stall, 0);
        check("rst_sel1", sel1, 0);
        check("rst_sel2", sel2, 0);
        check("rst_cnt", stall_cnt, 0);
        reset = 1'b0;
        idle(1);

        // ALU back-to-back: add x5 then consumer of x5
        issue(1'b1, 1'b0, 5'd5);
        tick();
        consumer(1'b1, 5'd5, 1'b0, 5'd0);
        settle();
        check("alu_sel1", sel1, 1);
        check("alu_opa", opa, 32'h11);
        check("alu_stall", stall, 0);
        tick();
        consumer(1'b0, 5'd0, 1'b1, 5'd5);
        settle();
        check("alu_s1_sel2", sel2, 2);
        check("alu_s1_opb", opb, 32'h22);
        idle(3);

        // Load-use: one stall cycle, then forward from stage 1
        issue(1'b1, 1'b1, 5'd6);
        tick();
        consumer(1'b0, 5'd0, 1'b1, 5'd6);
        settle();
        check("lu_stall", stall, 1);
        check("lu_sel2_stall", sel2, 1);
        check("lu_cnt_before", stall_cnt, 0);
        tick();
        settle();
        check("lu_stall_after", stall, 0);
        check("lu_sel2", sel2, 2);
        check("lu_opb", opb, 32'h22);
        check("lu_cnt", stall_cnt, 1);
        idle(3);

        // Youngest wins: x7 at stage 2 and stage 0
        issue(1'b1, 1'b0, 5'd7);
        tick();
        issue(1'b1, 1'b0, 5'd8);
        tick();
        issue(1'b1, 1'b0, 5'd7);
        tick();
        stage_data = {32'hAA, 32'h22, 32'hBB};
        consumer(1'b1, 5'd7, 1'b1, 5'd8);
        settle();
        check("yw_opa", opa, 32'hBB);
        check("yw_sel1", sel1, 1);
        check("yw_sel2", sel2, 2);
        check("yw_stall", stall, 0);
        // Two bubbles later the second add x7 sits in WB: forward beats the register file
        idle(2);
        consumer(1'b1, 5'd7, 1'b0, 5'd0);
        settle();
        check("wb_sel1", sel1, 3);
        check("wb_opa", opa, 32'hAA);
        idle(1);

        // Older ready producer must not mask a younger unready load
        stage_data = {32'h33, 32'h22, 32'h11};
        issue(1'b1, 1'b0, 5'd9);
        tick();
        issue(1'b1, 1'b1, 5'd9);
        tick();
        consumer(1'b1, 5'd9, 1'b0, 5'd0);
        settle();
        check("mask_stall", stall, 1);
        check("mask_sel1", sel1, 1);
        issue_valid = 1'b0;
        settle();
        check("novalid_stall", stall, 0);
        idle(3);

        // x0 source while stage 0 writes x0
        issue(1'b1, 1'b0, 5'd0);
        tick();
        rf1 = 32'h1234;
        consumer(1'b1, 5'd0, 1'b0, 5'd0);
        settle();
        check("x0_sel1", sel1, 0);
        check("x0_opa", opa, 0);
        check("x0_stall", stall, 0);
        idle(3);

        // Flush during load-use: decode instruction (writes x10) is squashed, load entry kept
        issue(1'b1, 1'b1, 5'd6);
        tick();
        consumer(1'b1, 5'd6, 1'b0, 5'd0);
        issue_regwrite = 1'b1;
        issue_rd       = 5'd10;
        flush          = 1'b1;
        settle();
        check("fl_stall", stall, 0);
        tick();
        rf1 = 32'h5;
        consumer(1'b1, 5'd10, 1'b1, 5'd6);
        settle();
        check("fl_opa", opa, 32'h5);
        check("fl_sel1", sel1, 0);
        check("fl_kept_sel2", sel2, 2);
        check("fl_cnt", stall_cnt, 1);
        idle(3);

        // Reset asserted mid-stall
        issue(1'b1, 1'b1, 5'd6);
        tick();
        rf1 = 32'h44;
        consumer(1'b1, 5'd6, 1'b0, 5'd0);
        settle();
        check("rm_stall_pre", stall, 1);
        reset = 1'b1;
        settle();
        check("rm_stall_in_rst", stall, 0);
        check("rm_sel1_in_rst", sel1, 0);
        tick();
        reset = 1'b0;
        settle();
        check("rm_stall", stall, 0);
        check("rm_sel1", sel1, 0);
        check("rm_opa", opa, 32'h44);
        check("rm_cnt", stall_cnt, 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
